// File: rtl/ntsc_modulator.sv
// ntsc_modulator: composite-video encoder stage after the NTSC timing generator.
// Converts a 4-bit RGB pixel into 6-bit luma and chroma DAC codes through a
// fixed 3-cycle pipeline. The pipeline stages are:
//   1. RGB->YIQ matrix and input capture.
//   2. Quadrature modulation from a sine LUT on the subcarrier phase.
//   3. Sync/blank/burst level insertion into the output registers.
// Ports:
//   clk, rst_n             pixel clock (25 MHz); asynchronous active-low reset
//   r, g, b                pixel colour, already zero outside active video
//   active, color_burst    active-video and burst windows
//   sync_n_in              composite sync, low = sync tip
//   chroma_disable         monochrome: chroma fixed at 32, burst suppressed
//   luma, chroma           6-bit DAC codes (luma 0 sync, 18 black, 63 white;
//                          chroma centred on 32)
module ntsc_modulator #(
  parameter int                 PHASE_W   = 24,
  parameter logic [PHASE_W-1:0] PHASE_INC = 24'd2402193,
  parameter logic [7:0]         PHASE_OFS = 8'd23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] r,
  input  logic [3:0] g,
  input  logic [3:0] b,
  input  logic       active,
  input  logic       color_burst,
  input  logic       sync_n_in,
  input  logic       chroma_disable,
  output logic [5:0] luma,
  output logic [5:0] chroma
);

  // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64.
  function automatic logic [6:0] quarter_sine(input logic [6:0] k);
    case (k)
      7'd0:  return 7'd0;   7'd1:  return 7'd3;   7'd2:  return 7'd6;   7'd3:  return 7'd9;
      7'd4:  return 7'd12;  7'd5:  return 7'd16;  7'd6:  return 7'd19;  7'd7:  return 7'd22;
      7'd8:  return 7'd25;  7'd9:  return 7'd28;  7'd10: return 7'd31;  7'd11: return 7'd34;
      7'd12: return 7'd37;  7'd13: return 7'd40;  7'd14: return 7'd43;  7'd15: return 7'd46;
      7'd16: return 7'd49;  7'd17: return 7'd51;  7'd18: return 7'd54;  7'd19: return 7'd57;
      7'd20: return 7'd60;  7'd21: return 7'd63;  7'd22: return 7'd65;  7'd23: return 7'd68;
      7'd24: return 7'd71;  7'd25: return 7'd73;  7'd26: return 7'd76;  7'd27: return 7'd78;
      7'd28: return 7'd81;  7'd29: return 7'd83;  7'd30: return 7'd85;  7'd31: return 7'd88;
      7'd32: return 7'd90;  7'd33: return 7'd92;  7'd34: return 7'd94;  7'd35: return 7'd96;
      7'd36: return 7'd98;  7'd37: return 7'd100; 7'd38: return 7'd102; 7'd39: return 7'd104;
      7'd40: return 7'd106; 7'd41: return 7'd107; 7'd42: return 7'd109; 7'd43: return 7'd111;
      7'd44: return 7'd112; 7'd45: return 7'd113; 7'd46: return 7'd115; 7'd47: return 7'd116;
      7'd48: return 7'd117; 7'd49: return 7'd118; 7'd50: return 7'd120; 7'd51: return 7'd121;
      7'd52: return 7'd122; 7'd53: return 7'd122; 7'd54: return 7'd123; 7'd55: return 7'd124;
      7'd56: return 7'd125; 7'd57: return 7'd125; 7'd58: return 7'd126; 7'd59: return 7'd126;
      7'd60: return 7'd126; default: return 7'd127;
    endcase
  endfunction

  // Full-wave LUT by quarter-wave symmetry; index wraps naturally mod 256.
  function automatic logic signed [7:0] sine_lut(input logic [7:0] k);
    logic [6:0] mag;
    mag = k[6] ? quarter_sine(7'd64 - {1'b0, k[5:0]}) : quarter_sine({1'b0, k[5:0]});
    return k[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  // Clamp a signed code into the 0..63 DAC range.
  function automatic logic [5:0] sat6(input logic signed [8:0] x);
    if (x < 9'sd0)       return 6'd0;
    else if (x > 9'sd63) return 6'd63;
    else                 return x[5:0];
  endfunction

  logic [PHASE_W-1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= '0;
    else        phase <= phase + PHASE_INC;
  end

  // Stage 1: RGB->YIQ matrix; the coefficients make white land exactly on I=Q=0.
  logic        [11:0] ysum_c;
  logic signed [12:0] r_s, g_s, b_s, isum_c, qsum_c;

  assign r_s    = $signed({9'd0, r});
  assign g_s    = $signed({9'd0, g});
  assign b_s    = $signed({9'd0, b});
  assign ysum_c = 12'd77 * {8'd0, r} + 12'd150 * {8'd0, g} + 12'd29 * {8'd0, b};
  assign isum_c = 13'sd153 * r_s - 13'sd70 * g_s - 13'sd83 * b_s;
  assign qsum_c = 13'sd54 * r_s - 13'sd134 * g_s + 13'sd80 * b_s;

  logic               sync_n_p0, act_p0, bur_p0, dis_p0;
  logic        [11:0] ysum_p0;
  logic signed [12:0] isum_p0, qsum_p0;
  logic        [7:0]  p_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_n_p0 <= 1'b1;
      act_p0    <= 1'b0;
      bur_p0    <= 1'b0;
      dis_p0    <= 1'b0;
    end else begin
      sync_n_p0 <= sync_n_in;
      act_p0    <= active;
      bur_p0    <= color_burst;
      dis_p0    <= chroma_disable;
    end
  end

  always_ff @(posedge clk) begin
    ysum_p0 <= ysum_c;
    isum_p0 <= isum_c;
    qsum_p0 <= qsum_c;
    p_p0    <= phase[PHASE_W-1 -: 8];
  end

  // Stage 2: quadrature modulation, burst carrier and luma scaling.
  logic signed [7:0]  s_i, s_q, s_b;
  logic signed [21:0] isum_x, qsum_x, s_i_x, s_q_x, cv_c;
  logic        [13:0] y3_c;

  assign s_i    = sine_lut(p_p0 + 8'd64 + PHASE_OFS);
  assign s_q    = sine_lut(p_p0 + PHASE_OFS);
  assign s_b    = sine_lut(p_p0);
  assign isum_x = {{9{isum_p0[12]}}, isum_p0};
  assign qsum_x = {{9{qsum_p0[12]}}, qsum_p0};
  assign s_i_x  = {{14{s_i[7]}}, s_i};
  assign s_q_x  = {{14{s_q[7]}}, s_q};
  assign cv_c   = isum_x * s_i_x + qsum_x * s_q_x;
  assign y3_c   = {2'b00, ysum_p0} * 14'd3;

  logic               sync_n_p1, act_p1, bur_p1, dis_p1;
  logic        [5:0]  lv_p1;
  logic signed [21:0] cv_p1;
  logic signed [7:0]  bv_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_n_p1 <= 1'b1;
      act_p1    <= 1'b0;
      bur_p1    <= 1'b0;
      dis_p1    <= 1'b0;
    end else begin
      sync_n_p1 <= sync_n_p0;
      act_p1    <= act_p0;
      bur_p1    <= bur_p0;
      dis_p1    <= dis_p0;
    end
  end

  always_ff @(posedge clk) begin
    lv_p1 <= 6'd18 + y3_c[13:8];
    cv_p1 <= cv_c;
    bv_p1 <= 8'sd0 - s_b;
  end

  // Stage 3: level insertion. Taking the top bits of cv/bv is the floor shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luma   <= 6'd18;
      chroma <= 6'd32;
    end else begin
      if (!sync_n_p1)  luma <= 6'd0;
      else if (act_p1) luma <= lv_p1;
      else             luma <= 6'd18;

      if (!sync_n_p1 || dis_p1) chroma <= 6'd32;
      else if (bur_p1)          chroma <= sat6(9'sd32 + $signed({{5{bv_p1[7]}}, bv_p1[7:4]}));
      else if (act_p1)          chroma <= sat6(9'sd32 + $signed({cv_p1[21], cv_p1[21:14]}));
      else                      chroma <= 6'd32;
    end
  end

endmodule

// File: tb/tb_ntsc_modulator.sv
// Testbench for ntsc_modulator: table-driven vectors plus randomized stimulus,
// checked against a real-arithmetic reference model with a 3-deep delay queue.
module tb_ntsc_modulator;

  localparam longint PHASE_MOD = 64'd16777216;
  localparam longint INC       = 64'd2402193;
  localparam int     OFS       = 23;
  localparam real    PI        = 3.14159265358979323846;

  typedef struct {
    logic [3:0] r, g, b;
    logic       act, bur, syn_n, dis;
    int         e_luma;    // -1: take from model
    int         e_chroma;  // -1: take from model
  } vec_t;

  typedef struct {
    int    l;
    int    c;
    string tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] r = '0, g = '0, b = '0;
  logic       active = 1'b0, color_burst = 1'b0, sync_n_in = 1'b1, chroma_disable = 1'b0;
  logic [5:0] luma, chroma;

  int     checks = 0;
  int     errors = 0;
  exp_t   q[$];
  longint ph_m = 0;
  vec_t   tbl[14];

  ntsc_modulator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .r             (r),
    .g             (g),
    .b             (b),
    .active        (active),
    .color_burst   (color_burst),
    .sync_n_in     (sync_n_in),
    .chroma_disable(chroma_disable),
    .luma          (luma),
    .chroma        (chroma)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int sine_ref(int k);
    int m;
    m = ((k % 256) + 256) % 256;
    return int'($floor(127.0 * $sin(2.0 * PI * m / 256.0) + 0.5));
  endfunction

  function automatic exp_t ref_model(vec_t v, int p, string tag);
    exp_t e;
    int   ysum, isum, qsum, cv, bv, c;
    ysum = 77 * int'(v.r) + 150 * int'(v.g) + 29 * int'(v.b);
    isum = 153 * int'(v.r) - 70 * int'(v.g) - 83 * int'(v.b);
    qsum = 54 * int'(v.r) - 134 * int'(v.g) + 80 * int'(v.b);
    cv   = isum * sine_ref(p + 64 + OFS) + qsum * sine_ref(p + OFS);
    bv   = -sine_ref(p);
    if (!v.syn_n)    e.l = 0;
    else if (v.act)  e.l = 18 + (ysum * 3) / 256;
    else             e.l = 18;
    if (!v.syn_n || v.dis) c = 32;
    else if (v.bur)        c = 32 + int'($floor(bv / 16.0));
    else if (v.act) begin
      c = 32 + int'($floor(cv / 16384.0));
      if (c < 0)  c = 0;
      if (c > 63) c = 63;
    end else c = 32;
    e.c   = c;
    e.tag = tag;
    return e;
  endfunction

  task automatic check(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // One clock: check the output due now, then drive the next sample.
  task automatic step(vec_t v, string tag);
    exp_t e;
    @(negedge clk);
    if (q.size() == 3) begin
      e = q.pop_front();
      check({e.tag, "_luma"}, int'(luma), e.l);
      check({e.tag, "_chroma"}, int'(chroma), e.c);
    end
    rst_n          = 1'b1;
    r              = v.r;
    g              = v.g;
    b              = v.b;
    active         = v.act;
    color_burst    = v.bur;
    sync_n_in      = v.syn_n;
    chroma_disable = v.dis;
    e = ref_model(v, int'(ph_m >> 16) & 255, tag);
    if (v.e_luma >= 0)   e.l = v.e_luma;
    if (v.e_chroma >= 0) e.c = v.e_chroma;
    q.push_back(e);
    ph_m = (ph_m + INC) % PHASE_MOD;
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    check("reset_luma", int'(luma), 18);
    check("reset_chroma", int'(chroma), 32);
    r              = 4'($urandom_range(0, 15));
    g              = 4'($urandom_range(0, 15));
    b              = 4'($urandom_range(0, 15));
    active         = 1'($urandom_range(0, 1));
    color_burst    = 1'($urandom_range(0, 1));
    sync_n_in      = 1'($urandom_range(0, 1));
    chroma_disable = 1'($urandom_range(0, 1));
  endtask

  // The two cleared stages emerge as 18/32 before the first real sample.
  task automatic arm_release();
    exp_t e;
    q.delete();
    e.l = 18; e.c = 32; e.tag = "post_reset";
    q.push_back(e);
    q.push_back(e);
    ph_m = 0;
  endtask

  function automatic vec_t mk(int rr, int gg, int bb, bit a, bit bu, bit sn, bit d);
    vec_t v;
    v.r = 4'(rr); v.g = 4'(gg); v.b = 4'(bb);
    v.act = a; v.bur = bu; v.syn_n = sn; v.dis = d;
    v.e_luma = -1; v.e_chroma = -1;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v = mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0);
    return v;
  endfunction

  initial begin
    vec_t v;
    //            r   g   b  act bur syn dis  luma chroma
    tbl[0]  = '{4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 63, 32};
    tbl[1]  = '{4'd0,  4'd0,  4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 18, 32};
    tbl[2]  = '{4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 0,  32};
    tbl[3]  = '{4'd15, 4'd0,  4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 31, -1};
    tbl[4]  = '{4'd15, 4'd0,  4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 31, -1};
    tbl[5]  = '{4'd15, 4'd0,  4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 31, 32};
    tbl[6]  = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 18, 32};
    tbl[7]  = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 18, -1};
    tbl[8]  = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b1, 1'b1, 1'b1, 18, 32};
    tbl[9]  = '{4'd0,  4'd15, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 44, -1};
    tbl[10] = '{4'd0,  4'd0,  4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 23, -1};
    tbl[11] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 0,  32};
    tbl[12] = '{4'd15, 4'd0,  4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 31, 32};
    tbl[13] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 0,  32};

    // Reset held with random inputs, then release into blanking.
    for (int i = 0; i < 5; i++) rst_cycle();
    arm_release();
    for (int i = 0; i < 6; i++) step(mk(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0), "blank");

    for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Sync tip over a white line and its release.
    for (int i = 0; i < 4; i++) step(mk(15, 15, 15, 1'b1, 1'b0, 1'b1, 1'b0), "white");
    for (int i = 0; i < 5; i++) step(mk(15, 15, 15, 1'b1, 1'b0, 1'b0, 1'b0), "sync_white");
    for (int i = 0; i < 5; i++) step(mk(15, 15, 15, 1'b1, 1'b0, 1'b1, 1'b0), "white_after_sync");

    // Burst window: per-sample model comparison plus range.
    for (int i = 0; i < 64; i++) begin
      step(mk(0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0), "burst");
      if (i >= 3) begin
        checks++;
        if (chroma < 6'd24 || chroma > 6'd40) begin
          errors++;
          $display("FAIL burst_range: got %0d, want 24..40", chroma);
        end
      end
    end
    for (int i = 0; i < 32; i++) step(mk(0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1), "burst_disabled");

    // Saturated red over many subcarrier cycles (phase wraps every ~7 clocks).
    for (int i = 0; i < 48; i++) begin
      v = mk(15, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      v.e_luma = 31;
      step(v, "red");
    end
    for (int i = 0; i < 16; i++) step(mk(15, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0), "red_burst");

    for (int i = 0; i < 400; i++) step(rand_vec(), "rand");

    // Asynchronous reset mid-line.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_luma", int'(luma), 18);
    check("async_reset_chroma", int'(chroma), 32);
    for (int i = 0; i < 3; i++) rst_cycle();
    arm_release();
    for (int i = 0; i < 200; i++) step(rand_vec(), "rand2");
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0), "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
